// File: rtl/axi_lsu_master_if.sv
`default_nettype none
// ============================================================================
// axi_lsu_master_if : AXI4-Lite bus bundle between the load/store unit and data memory
// Revision: 1.0
// ============================================================================
interface axi_lsu_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    M_AXI_AWVALID;
   logic                    M_AXI_AWREADY;
   logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
   logic [2:0]              M_AXI_AWPROT;
   logic                    M_AXI_WVALID;
   logic                    M_AXI_WREADY;
   logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
   logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
   logic                    M_AXI_BVALID;
   logic                    M_AXI_BREADY;
   logic [1:0]              M_AXI_BRESP;
   logic                    M_AXI_ARVALID;
   logic                    M_AXI_ARREADY;
   logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
   logic [2:0]              M_AXI_ARPROT;
   logic                    M_AXI_RVALID;
   logic                    M_AXI_RREADY;
   logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
   logic [1:0]              M_AXI_RRESP;

   modport master (
      output M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
      output M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
      output M_AXI_BREADY,
      output M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
      output M_AXI_RREADY,
      input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
      input  M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
   );

   modport slave (
      input  M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
      input  M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
      input  M_AXI_BREADY,
      input  M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
      input  M_AXI_RREADY,
      output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
      output M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
   );
endinterface
`default_nettype wire

// File: rtl/axi_lsu_master.sv
`default_nettype none
// ============================================================================
// axi_lsu_master : RV32I load/store request to single AXI4-Lite transaction
// Revision: 1.0
// ============================================================================
module axi_lsu_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  wire                   CLK,
   input  wire                   RSTn,
   input  wire                   req_valid,
   output logic                  req_ready,
   input  wire                   req_we,
   input  wire  [2:0]            req_funct3,
   input  wire  [ADDR_WIDTH-1:0] req_addr,
   input  wire  [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy,
   axi_lsu_master_if.master      m_axi
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WRITE      = 3'd1,
      S_WRITE_RESP = 3'd2,
      S_READ_ADDR  = 3'd3,
      S_READ_DATA  = 3'd4,
      S_RESP       = 3'd5
   } state_t;

   state_t                r_state;
   logic [2:0]            r_funct3;
   logic [1:0]            r_off;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [3:0]            r_wstrb;
   logic                  r_awvalid;
   logic                  r_wvalid;
   logic                  r_bready;
   logic                  r_arvalid;
   logic                  r_rready;
   logic                  r_rsp_valid;
   logic                  r_rsp_err;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;

   logic                  w_misaligned;
   logic                  w_illegal;
   logic                  w_req_err;
   logic [3:0]            w_strb;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [DATA_WIDTH-1:0] w_shifted;
   logic [DATA_WIDTH-1:0] w_load;

   always_comb begin
      w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      if (req_we)
         w_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
      else
         w_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
      w_req_err = w_misaligned || w_illegal;
   end

   // Sub-word stores replicate the lane so the strobe alone selects the bytes.
   always_comb begin
      w_strb  = 4'b1111;
      w_wdata = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            w_strb  = 4'b0001 << req_addr[1:0];
            w_wdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_strb  = 4'b0011 << req_addr[1:0];
            w_wdata = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      w_shifted = m_axi.M_AXI_RDATA >> {r_off, 3'b000};
      case (r_funct3)
         3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b100:  w_load = {24'd0, w_shifted[7:0]};
         3'b101:  w_load = {16'd0, w_shifted[15:0]};
         default: w_load = w_shifted;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state     <= S_IDLE;
         r_funct3    <= 3'd0;
         r_off       <= 2'd0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= 4'd0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_funct3 <= req_funct3;
                  r_off    <= req_addr[1:0];
                  if (w_req_err) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                  end else if (req_we) begin
                     r_addr    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                     r_wdata   <= w_wdata;
                     r_wstrb   <= w_strb;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= S_WRITE;
                  end else begin
                     r_addr    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                     r_arvalid <= 1'b1;
                     r_state   <= S_READ_ADDR;
                  end
               end
            end
            S_WRITE: begin
               // AW and W retire independently; move on once neither is pending.
               if (m_axi.M_AXI_AWREADY) r_awvalid <= 1'b0;
               if (m_axi.M_AXI_WREADY)  r_wvalid  <= 1'b0;
               if ((!r_awvalid || m_axi.M_AXI_AWREADY) && (!r_wvalid || m_axi.M_AXI_WREADY)) begin
                  r_bready <= 1'b1;
                  r_state  <= S_WRITE_RESP;
               end
            end
            S_WRITE_RESP: begin
               if (m_axi.M_AXI_BVALID) begin
                  r_bready    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= (m_axi.M_AXI_BRESP != 2'b00);
                  r_rsp_rdata <= '0;
                  r_state     <= S_RESP;
               end
            end
            S_READ_ADDR: begin
               if (m_axi.M_AXI_ARREADY) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= S_READ_DATA;
               end
            end
            S_READ_DATA: begin
               if (m_axi.M_AXI_RVALID) begin
                  r_rready    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= (m_axi.M_AXI_RRESP != 2'b00);
                  r_rsp_rdata <= (m_axi.M_AXI_RRESP != 2'b00) ? '0 : w_load;
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               r_rsp_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;

   assign m_axi.M_AXI_AWVALID = r_awvalid;
   assign m_axi.M_AXI_AWADDR  = r_addr;
   assign m_axi.M_AXI_AWPROT  = 3'b000;
   assign m_axi.M_AXI_WVALID  = r_wvalid;
   assign m_axi.M_AXI_WDATA   = r_wdata;
   assign m_axi.M_AXI_WSTRB   = r_wstrb;
   assign m_axi.M_AXI_BREADY  = r_bready;
   assign m_axi.M_AXI_ARVALID = r_arvalid;
   assign m_axi.M_AXI_ARADDR  = r_addr;
   assign m_axi.M_AXI_ARPROT  = 3'b000;
   assign m_axi.M_AXI_RREADY  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi_lsu_master.sv
`default_nettype none
// ============================================================================
// tb_axi_lsu_master : scoreboard bench with reference model and random AXI slave
// Revision: 1.0
// ============================================================================
module tb_axi_lsu_master;

   logic        CLK = 1'b0;
   logic        RSTn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   axi_lsu_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axi_lsu_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .m_axi      (bus)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
      int          lat;
   } rsp_exp_t;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [1:0]  resp;
      int          d0;
      int          d1;
      int          d2;
      bit          r_hold;
   } axi_exp_t;

   rsp_exp_t rspq[$];
   axi_exp_t axq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Architectural meaning of a request: legality, byte lanes, and the loaded value.
   function automatic void model(input bit we, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] resp,
                                 output bit axi, output bit err, output logic [31:0] rdata,
                                 output logic [3:0] strb, output logic [31:0] wdata);
      int          nbytes;
      int          ofs;
      bit          legal;
      logic [31:0] mask;
      logic [31:0] v;
      nbytes = 1 << f[1:0];
      ofs    = int'(a % 4);
      legal  = we ? (f inside {3'd0, 3'd1, 3'd2}) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      axi    = legal && ((a % nbytes) == 0);
      err    = !axi;
      strb   = 4'd0;
      wdata  = 32'd0;
      rdata  = 32'd0;
      if (!axi) return;
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            wdata[8*i +: 8] = wd[8*(i % nbytes) +: 8];
            if (i >= ofs && i < ofs + nbytes) strb[i] = 1'b1;
         end
         err = (resp != 2'b00);
      end else begin
         mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nbytes)) - 32'd1);
         v    = (rd >> (8*ofs)) & mask;
         if (!f[2] && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
         if (resp != 2'b00) begin
            err = 1'b1;
            v   = 32'd0;
         end
         rdata = v;
      end
   endfunction

   // ---------------- response monitor ----------------
   initial begin
      rsp_exp_t e;
      forever begin
         @(negedge CLK);
         if (RSTn && rsp_valid) begin
            if (rspq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 required no response (cycle %0d)", cyc);
            end else begin
               e = rspq.pop_front();
               check("rsp_rdata", rsp_rdata, e.rdata);
               check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
               check("rsp_latency", cyc - e.acc, e.lat);
            end
         end
      end
   end

   // ---------------- AXI slave ----------------
   bit   aw_seen, w_seen, ar_seen, aw_act, w_act, ar_act;
   int   aw_cnt, w_cnt, b_cnt, r_cnt, ar_cnt;
   logic last_bready, last_rready;

   task automatic slave_clear();
      bus.M_AXI_AWREADY = 1'b0;
      bus.M_AXI_WREADY  = 1'b0;
      bus.M_AXI_BVALID  = 1'b0;
      bus.M_AXI_BRESP   = 2'b00;
      bus.M_AXI_ARREADY = 1'b0;
      bus.M_AXI_RVALID  = 1'b0;
      bus.M_AXI_RDATA   = 32'd0;
      bus.M_AXI_RRESP   = 2'b00;
      aw_seen = 0; w_seen = 0; ar_seen = 0; aw_act = 0; w_act = 0; ar_act = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0; ar_cnt = 0;
      last_bready = 1'b0;
      last_rready = 1'b0;
      axq.delete();
   endtask

   initial begin
      axi_exp_t cur;
      axi_exp_t dump;
      slave_clear();
      forever begin
         @(negedge CLK);
         if (!RSTn) begin
            slave_clear();
            continue;
         end
         if (bus.M_AXI_AWREADY) begin
            bus.M_AXI_AWREADY = 1'b0; aw_seen = 1; aw_act = 0;
            check("awvalid_drop", {31'd0, bus.M_AXI_AWVALID}, 32'd0);
         end
         if (bus.M_AXI_WREADY) begin
            bus.M_AXI_WREADY = 1'b0; w_seen = 1; w_act = 0;
            check("wvalid_drop", {31'd0, bus.M_AXI_WVALID}, 32'd0);
         end
         if (bus.M_AXI_ARREADY) begin
            bus.M_AXI_ARREADY = 1'b0; ar_seen = 1; ar_act = 0;
            check("arvalid_drop", {31'd0, bus.M_AXI_ARVALID}, 32'd0);
         end
         if (bus.M_AXI_BVALID && last_bready) begin
            bus.M_AXI_BVALID = 1'b0; aw_seen = 0; w_seen = 0; b_cnt = 0;
            if (axq.size() > 0) dump = axq.pop_front();
         end
         if (bus.M_AXI_RVALID && last_rready) begin
            bus.M_AXI_RVALID = 1'b0; ar_seen = 0; r_cnt = 0;
            if (axq.size() > 0) dump = axq.pop_front();
         end
         if (bus.M_AXI_BREADY)
            check("bready_after_aw_w", {31'd0, aw_seen && w_seen}, 32'd1);
         if (axq.size() == 0) begin
            if (bus.M_AXI_AWVALID || bus.M_AXI_WVALID || bus.M_AXI_ARVALID) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_axi: got aw/w/ar valid=%b%b%b required 000",
                        bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID);
            end
         end else begin
            cur = axq[0];
            if (bus.M_AXI_AWVALID && !aw_seen) begin
               aw_act = 1;
               if (aw_cnt >= cur.d0) begin
                  bus.M_AXI_AWREADY = 1'b1; aw_cnt = 0;
                  check("awaddr", bus.M_AXI_AWADDR, cur.addr);
                  check("awprot", {29'd0, bus.M_AXI_AWPROT}, 32'd0);
                  check("aw_is_store", {31'd0, cur.we}, 32'd1);
               end else aw_cnt++;
            end else if (aw_act) check("awvalid_held", {31'd0, bus.M_AXI_AWVALID}, 32'd1);
            if (bus.M_AXI_WVALID && !w_seen) begin
               w_act = 1;
               if (w_cnt >= cur.d1) begin
                  bus.M_AXI_WREADY = 1'b1; w_cnt = 0;
                  check("wdata", bus.M_AXI_WDATA, cur.wdata);
                  check("wstrb", {28'd0, bus.M_AXI_WSTRB}, {28'd0, cur.strb});
               end else w_cnt++;
            end else if (w_act) check("wvalid_held", {31'd0, bus.M_AXI_WVALID}, 32'd1);
            if (bus.M_AXI_ARVALID && !ar_seen) begin
               ar_act = 1;
               if (ar_cnt >= cur.d0) begin
                  bus.M_AXI_ARREADY = 1'b1; ar_cnt = 0;
                  check("araddr", bus.M_AXI_ARADDR, cur.addr);
                  check("arprot", {29'd0, bus.M_AXI_ARPROT}, 32'd0);
                  check("ar_is_load", {31'd0, cur.we}, 32'd0);
               end else ar_cnt++;
            end else if (ar_act) check("arvalid_held", {31'd0, bus.M_AXI_ARVALID}, 32'd1);
            if (aw_seen && w_seen && !bus.M_AXI_BVALID) begin
               if (b_cnt >= cur.d2) begin
                  bus.M_AXI_BVALID = 1'b1; bus.M_AXI_BRESP = cur.resp;
               end else b_cnt++;
            end
            if (ar_seen && !bus.M_AXI_RVALID && !cur.r_hold) begin
               if (r_cnt >= cur.d1) begin
                  bus.M_AXI_RVALID = 1'b1; bus.M_AXI_RDATA = cur.rdata; bus.M_AXI_RRESP = cur.resp;
               end else r_cnt++;
            end
         end
         last_bready = bus.M_AXI_BREADY;
         last_rready = bus.M_AXI_RREADY;
      end
   end

   // ---------------- driver ----------------
   task automatic do_reset();
      #2 RSTn = 1'b0;
      req_valid = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      rspq.delete();
      #2 RSTn = 1'b1;
   endtask

   // d0/d1/d2 = AW/W/B waits for stores, AR/R waits for loads.
   task automatic issue(input bit we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input logic [1:0] resp,
                        input int d0, input int d1, input int d2, input bit r_hold);
      bit          axi, err;
      logic [31:0] rdata, wdata;
      logic [3:0]  strb;
      rsp_exp_t    re;
      axi_exp_t    ae;
      bit          seen;
      int          k;
      k = 0;
      while (!req_ready && k < 64) begin
         @(negedge CLK);
         k++;
      end
      model(we, f, a, wd, rd, resp, axi, err, rdata, strb, wdata);
      re.rdata = rdata; re.err = err; re.acc = cyc;
      re.lat   = !axi ? 1 : (we ? 3 + ((d0 > d1) ? d0 : d1) + d2 : 3 + d0 + d1);
      if (!r_hold) rspq.push_back(re);
      if (axi) begin
         ae.we = we; ae.addr = a & 32'hFFFF_FFFC; ae.strb = strb; ae.wdata = wdata;
         ae.rdata = rd; ae.resp = resp; ae.d0 = d0; ae.d1 = d1; ae.d2 = d2; ae.r_hold = r_hold;
         axq.push_back(ae);
      end
      req_valid = 1'b1; req_we = we; req_funct3 = f; req_addr = a; req_wdata = wd;
      @(posedge CLK);
      @(negedge CLK);
      req_valid  = 1'($urandom);
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      check("ready_after_accept", {31'd0, req_ready}, 32'd0);
      if (r_hold) begin
         req_valid = 1'b0;
         return;
      end
      seen = 0;
      for (int i = 0; i < 64 && !seen; i++) begin
         if (rsp_valid) seen = 1;
         else @(negedge CLK);
      end
      req_valid = 1'b0;
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rsp_timeout: got no rsp_valid within 64 cycles required one");
         do_reset();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RSTn = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
      repeat (3) @(negedge CLK);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_valids", {27'd0, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                           bus.M_AXI_BREADY, bus.M_AXI_RREADY}, 32'd0);
      check("rst_awaddr", bus.M_AXI_AWADDR, 32'd0);
      check("rst_wdata", bus.M_AXI_WDATA, 32'd0);
      check("rst_wstrb", {28'd0, bus.M_AXI_WSTRB}, 32'd0);
      #2 RSTn = 1'b1;
      @(negedge CLK);

      issue(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'd0, 2'b00, 0, 0, 0, 0);
      issue(1, 3'b000, 32'h103, 32'h000000AB, 32'd0, 2'b00, 0, 0, 0, 0);
      issue(0, 3'b000, 32'h102, 32'd0, 32'h12803456, 2'b00, 0, 0, 0, 0);
      issue(0, 3'b100, 32'h102, 32'd0, 32'h12803456, 2'b00, 0, 0, 0, 0);
      issue(0, 3'b001, 32'h102, 32'd0, 32'h12803456, 2'b00, 0, 0, 0, 0);
      issue(0, 3'b001, 32'h101, 32'd0, 32'h12803456, 2'b00, 0, 0, 0, 0);
      issue(1, 3'b011, 32'h10,  32'h55555555, 32'd0, 2'b00, 0, 0, 0, 0);
      issue(1, 3'b010, 32'h20,  32'hCAFEF00D, 32'd0, 2'b10, 3, 0, 0, 0);
      issue(1, 3'b001, 32'h22,  32'h0000BEEF, 32'd0, 2'b00, 2, 2, 1, 0);
      issue(0, 3'b010, 32'h40,  32'd0, 32'h87654321, 2'b11, 1, 2, 0, 0);

      // Reset in the middle of a read whose data never arrives.
      issue(0, 3'b010, 32'h80, 32'd0, 32'hFFFFFFFF, 2'b00, 0, 0, 0, 1);
      for (int i = 0; i < 8 && !bus.M_AXI_RREADY; i++) @(negedge CLK);
      check("rready_before_reset", {31'd0, bus.M_AXI_RREADY}, 32'd1);
      #2 RSTn = 1'b0;
      #1;
      check("reset_rready", {31'd0, bus.M_AXI_RREADY}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_arvalid", {31'd0, bus.M_AXI_ARVALID}, 32'd0);
      check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      #2 RSTn = 1'b1;
      @(negedge CLK);
      issue(0, 3'b101, 32'h82, 32'd0, 32'h8001ABCD, 2'b00, 0, 0, 0, 0);

      for (int n = 0; n < 250; n++) begin
         logic [1:0] rs;
         rs = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         issue(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, rs,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 0);
      end

      repeat (4) @(negedge CLK);
      if (rspq.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rsp_queue_drain: got %0d pending required 0", rspq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi_lsu_master.md
Name: axi_lsu_master

Overview:
Load/store bus master for the riscv_cpu memory stage. It converts one RV32I load or store request (address, funct3, store data) into a single AXI4-Lite transaction toward the data memory. It returns load data that is already aligned and sign- or zero-extended. While a transaction is in flight the block is busy, and the pipeline stalls on it.

Parameters:
ADDR_WIDTH, 32, AXI and request address width
DATA_WIDTH, 32, AXI data width; fixed at 32 (RV32I)

Ports:
CLK  input  1  clock
RSTn  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I load/store funct3
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data (rs2)
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  misaligned access, illegal funct3, or non-OKAY response
busy  output  1  high from acceptance through the rsp_valid cycle
M_AXI_AWVALID/AWREADY/AWADDR/AWPROT, M_AXI_WVALID/WREADY/WDATA/WSTRB, M_AXI_BVALID/BREADY/BRESP, M_AXI_ARVALID/ARREADY/ARADDR/ARPROT, M_AXI_RVALID/RREADY/RDATA/RRESP  AXI4-Lite master  widths per AXI config (addr 32, data 32, strb 4, prot 3, resp 2)

Behaviour:
- Reset (RSTn low, asynchronous): state IDLE; all VALID/READY, rsp_valid, rsp_err and busy are 0; rsp_rdata, AXI addr/data/strb are 0. Reset mid-transaction drops every VALID immediately; there is no response.
- States: IDLE, WRITE, WRITE_RESP, READ_ADDR, READ_DATA, RESP.
- Acceptance: all request fields are latched on the accept cycle. Request inputs are ignored outside IDLE.
- Legality check at accept:
  - Misaligned: funct3[1:0]=01 with addr[0]=1, or funct3[1:0]=10 with addr[1:0]!=0.
  - Illegal funct3 for loads: 011, 110, 111.
  - Illegal funct3 for stores: anything other than 000/001/010.
  - On any violation go to RESP with rsp_err=1 and rsp_rdata=0. No AXI activity occurs.
- AXI addresses are word-aligned: {addr[31:2],2'b00}. AWPROT = ARPROT = 3'b000.
- Store path:
  - WSTRB: SB gives 4'b0001<<addr[1:0]; SH gives 4'b0011<<addr[1:0]; SW gives 4'b1111.
  - WDATA: SB gives {4{wdata[7:0]}}; SH gives {2{wdata[15:0]}}; SW gives wdata.
  - WRITE: AWVALID and WVALID rise in the cycle after accept. Each is held, with payload stable, until its own handshake, then drops independently.
  - WRITE_RESP is entered once both handshakes are done. BREADY=1 in WRITE_RESP only.
  - On the B handshake go to RESP; rsp_err = (BRESP != 2'b00).
- Load path:
  - READ_ADDR: ARVALID rises in the cycle after accept and is held until ARREADY.
  - READ_DATA: RREADY=1. On the R handshake capture RDATA.
  - Shift right by addr[1:0]*8, then extend: LB sign-extends 8 bits, LH sign-extends 16, LW passes through, LBU zero-extends 8, LHU zero-extends 16.
  - RRESP != OKAY gives rsp_err=1 and rsp_rdata=0.
- RESP: rsp_valid=1 for exactly one cycle, then return to IDLE. rsp_rdata and rsp_err are valid only while rsp_valid=1 and are held until the next response.
- Latency with a zero-wait slave: accept at cycle 0, AXI handshake(s) at cycle 1 (B or R at cycle 2), rsp_valid at cycle 3. An error response occurs at cycle 1.
- A VALID is never withdrawn before its handshake (AXI rule); the only exception is reset.
- Simultaneous AWREADY and WREADY in the same cycle: both handshakes complete, and WRITE_RESP is entered the next cycle.

Test Plan:
- SW 0xDEADBEEF @0x10, slave zero-wait: AWADDR=0x10, WSTRB=4'b1111, WDATA=0xDEADBEEF, BRESP=OKAY; rsp_valid at cycle 3, rsp_err=0.
- SB data 0x000000AB @0x103: AWADDR=0x100, WSTRB=4'b1000, WDATA=0xABABABAB.
- LB @0x102 with RDATA=0x12803456: rsp_rdata=0xFFFFFF80. LBU at the same address: rsp_rdata=0x00000080. LH @0x102: rsp_rdata=0x00001280.
- LH @0x101: no ARVALID ever; rsp_valid at cycle 1 with rsp_err=1 and rsp_rdata=0. Store with funct3=011: same result.
- Store with AWREADY delayed 3 cycles and WREADY immediate: WVALID drops after 1 cycle while AWVALID is held 4 cycles. BREADY only after both. BRESP=2'b10 gives rsp_err=1.
- Load with ARREADY at cycle 1 and RVALID withheld: assert RSTn=0 mid-READ_DATA. RREADY and busy go to 0 immediately, no rsp_valid, and the next request is accepted normally.
